// File: rtl/count_checker_if.sv
// count_checker_if: observed-counter sample inputs and checker result outputs
//    enable, count          : observed counter enable and value (master -> slave)
//    expected, err          : prediction for next sample, one-cycle mismatch pulse
//    err_count, wrap_count  : mismatch tally and legal wrap tally
//    halted                 : checker has stopped after max_err mismatches
interface count_checker_if;
   logic        enable;
   logic [15:0] count;
   logic [15:0] expected;
   logic        err;
   logic [7:0]  err_count;
   logic [15:0] wrap_count;
   logic        halted;
   modport master (output enable, count, input expected, err, err_count, wrap_count, halted);
   modport slave  (input enable, count, output expected, err, err_count, wrap_count, halted);
endinterface

// File: rtl/count_checker.sv
// count_checker: tracks a modulo-n counter and flags, tallies and halts on mismatches
//    clock : rising-edge clock
//    reset : asynchronous active-low reset
//    bus   : count_checker_if.slave (enable/count in; expected/err/err_count/wrap_count/halted out)
module count_checker #(
   parameter int n       = 8,
   parameter int max_err = 15
) (
   input logic             clock,
   input logic             reset,
   count_checker_if.slave  bus
);
   localparam logic [1:0] SYNC  = 2'd0;
   localparam logic [1:0] TRACK = 2'd1;
   localparam logic [1:0] HALT  = 2'd2;
   logic [1:0]  state_q, state_d;
   logic [15:0] ref_q, ref_d;
   logic [15:0] exp_q, exp_d;
   logic        err_q, err_d;
   logic [7:0]  ec_q, ec_d;
   logic [15:0] wc_q, wc_d;
   logic [16:0] sum;
   logic [15:0] pred;
   logic        in_range, bad;
   // 17-bit arithmetic so count = 65534 with n = 65535 rolls to 0 without overflow;
   // an in-range count plus one can only reach n, never exceed it
   assign sum      = {1'b0, bus.count} + 17'd1;
   assign in_range = {1'b0, bus.count} < 17'(n);
   assign pred     = bus.enable ? (sum >= 17'(n) ? 16'd0 : sum[15:0]) : bus.count;
   assign bad      = !in_range || (state_q == TRACK && bus.count != exp_q);
   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      exp_d   = exp_q;
      err_d   = 1'b0;
      ec_d    = ec_q;
      wc_d    = wc_q;
      if (state_q != HALT) begin
         err_d = bad;
         ec_d  = bad ? ec_q + 8'd1 : ec_q;
         if (bad && ec_q + 8'd1 == 8'(max_err))
            state_d = HALT;
         else if (!in_range)
            state_d = SYNC;
         else begin
            // a good sample (first sync, match, or resync after a mismatch) becomes the new reference
            state_d = TRACK;
            ref_d   = bus.count;
            exp_d   = pred;
            if (!bad && state_q == TRACK && ref_q == 16'(n - 1) && bus.count == 16'd0)
               wc_d = wc_q + 16'd1;
         end
      end
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= SYNC;
         ref_q   <= '0;
         exp_q   <= '0;
         err_q   <= 1'b0;
         ec_q    <= '0;
         wc_q    <= '0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         exp_q   <= exp_d;
         err_q   <= err_d;
         ec_q    <= ec_d;
         wc_q    <= wc_d;
      end
   end
   assign bus.expected   = exp_q;
   assign bus.err        = err_q;
   assign bus.err_count  = ec_q;
   assign bus.wrap_count = wc_q;
   assign bus.halted     = state_q == HALT;
endmodule

// File: tb/tb_count_checker.sv
// tb_count_checker: directed table and corner-case sequences for count_checker
module tb_count_checker;
   typedef struct {
      logic        en;
      logic [15:0] cnt;
      logic [15:0] exp;
      logic        err;
      logic [7:0]  ec;
      logic [15:0] wc;
   } vec_t;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        en    = 1'b0;
   logic [15:0] cnt   = '0;
   int          n_chk = 0;
   int          n_bad = 0;
   vec_t        tbl[$];
   count_checker_if ia ();
   count_checker_if ib ();
   count_checker_if ic ();
   assign ia.enable = en;
   assign ia.count  = cnt;
   assign ib.enable = en;
   assign ib.count  = cnt;
   assign ic.enable = en;
   assign ic.count  = cnt;
   count_checker #(.n(8),     .max_err(15)) dut_a (.clock(clock), .reset(reset), .bus(ia));
   count_checker #(.n(8),     .max_err(3))  dut_b (.clock(clock), .reset(reset), .bus(ib));
   count_checker #(.n(65535), .max_err(15)) dut_c (.clock(clock), .reset(reset), .bus(ic));
   always #5 clock = ~clock;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, req);
      end
   endtask
   // drive away from the edge, then sample 1 time unit after the next rising edge
   task automatic step(input logic e, input logic [15:0] c);
      en  = e;
      cnt = c;
      @(posedge clock);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask
   task automatic add(input logic e, input logic [15:0] c, input logic [15:0] x, input logic r,
                      input logic [7:0] ec, input logic [15:0] wc);
      tbl.push_back('{en: e, cnt: c, exp: x, err: r, ec: ec, wc: wc});
   endtask
   initial begin
      for (int i = 0; i < 20; i++)
         add(i != 19, 16'(i % 8), i == 19 ? 16'd3 : 16'((i + 1) % 8), 1'b0, 8'd0,
             i >= 16 ? 16'd2 : i >= 8 ? 16'd1 : 16'd0);
      add(0, 4, 4, 1, 1, 2);
      add(0, 4, 4, 0, 1, 2);
      add(1, 4, 5, 0, 1, 2);
      add(1, 9, 5, 1, 2, 2);
      add(1, 2, 3, 0, 2, 2);
      add(1, 3, 4, 0, 2, 2);
      add(1, 8, 4, 1, 3, 2);
      add(1, 7, 0, 0, 3, 2);
      add(1, 0, 1, 0, 3, 3);
      // reset held low across edges with junk inputs
      en  = 1'b1;
      cnt = 16'd9;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("rst_expected", 32'(ia.expected), 0);
      chk("rst_err", 32'(ia.err), 0);
      chk("rst_err_count", 32'(ia.err_count), 0);
      chk("rst_wrap_count", 32'(ia.wrap_count), 0);
      chk("rst_halted", 32'(ia.halted), 0);
      reset = 1'b1;
      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].cnt);
         chk($sformatf("vec%0d_expected", i), 32'(ia.expected), 32'(tbl[i].exp));
         chk($sformatf("vec%0d_err", i), 32'(ia.err), 32'(tbl[i].err));
         chk($sformatf("vec%0d_err_count", i), 32'(ia.err_count), 32'(tbl[i].ec));
         chk($sformatf("vec%0d_wrap_count", i), 32'(ia.wrap_count), 32'(tbl[i].wc));
         chk($sformatf("vec%0d_halted", i), 32'(ia.halted), 0);
      end
      // first sample out of range stays in SYNC, next good sample locks on
      do_reset();
      step(1, 9);
      chk("sync9_err", 32'(ia.err), 1);
      chk("sync9_err_count", 32'(ia.err_count), 1);
      step(1, 2);
      chk("sync2_err", 32'(ia.err), 0);
      chk("sync2_expected", 32'(ia.expected), 3);
      chk("sync2_err_count", 32'(ia.err_count), 1);
      // max_err = 3 halts on third mismatch
      do_reset();
      step(1, 0);
      chk("h0_expected", 32'(ib.expected), 1);
      step(1, 5);
      chk("h1_err", 32'(ib.err), 1);
      chk("h1_err_count", 32'(ib.err_count), 1);
      step(1, 0);
      chk("h2_err_count", 32'(ib.err_count), 2);
      chk("h2_halted", 32'(ib.halted), 0);
      step(1, 7);
      chk("h3_err", 32'(ib.err), 1);
      chk("h3_err_count", 32'(ib.err_count), 3);
      chk("h3_halted", 32'(ib.halted), 1);
      step(1, 3);
      chk("h4_err", 32'(ib.err), 0);
      chk("h4_err_count", 32'(ib.err_count), 3);
      chk("h4_halted", 32'(ib.halted), 1);
      step(1, 12);
      chk("h5_err", 32'(ib.err), 0);
      chk("h5_err_count", 32'(ib.err_count), 3);
      // asynchronous reset between edges while halted
      #3 reset = 1'b0;
      #1;
      chk("ar_halted", 32'(ib.halted), 0);
      chk("ar_err_count", 32'(ib.err_count), 0);
      chk("ar_expected", 32'(ib.expected), 0);
      chk("ar_err", 32'(ib.err), 0);
      chk("ar_wrap_count", 32'(ib.wrap_count), 0);
      #1 reset = 1'b1;
      step(1, 4);
      chk("ar_resume_expected", 32'(ib.expected), 5);
      chk("ar_resume_err", 32'(ib.err), 0);
      step(1, 6);
      chk("ar_check_err", 32'(ib.err), 1);
      chk("ar_check_err_count", 32'(ib.err_count), 1);
      // n = 65535 wrap at the top of the 16-bit range
      do_reset();
      step(1, 65533);
      chk("big0_expected", 32'(ic.expected), 65534);
      step(1, 65534);
      chk("big1_expected", 32'(ic.expected), 0);
      chk("big1_err", 32'(ic.err), 0);
      step(1, 0);
      chk("big2_err", 32'(ic.err), 0);
      chk("big2_wrap_count", 32'(ic.wrap_count), 1);
      chk("big2_expected", 32'(ic.expected), 1);
      chk("big2_err_count", 32'(ic.err_count), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end
endmodule
